// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: fixed-latency channel A beats a FIFO-buffered channel B,
// with a starvation stall request. Optional WB_SCOREBOARD_EN adds a pending-write query port.
module writeback_arbiter #(
  parameter int unsigned BIT_COUNT      = 32,
  parameter int unsigned REGISTER_COUNT = 32,
  parameter int unsigned QUEUE_DEPTH    = 4,
  parameter int unsigned MAX_STARVE     = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              AValid,
  input  logic [$clog2(REGISTER_COUNT)-1:0] ARd,
  input  logic [BIT_COUNT-1:0]              AData,
  input  logic                              BValid,
  output logic                              BReady,
  input  logic [$clog2(REGISTER_COUNT)-1:0] BRd,
  input  logic [BIT_COUNT-1:0]              BData,
  output logic                              PipeStall,
  output logic [$clog2(QUEUE_DEPTH):0]      Pending,
  output logic                              WriteEnable,
  output logic [$clog2(REGISTER_COUNT)-1:0] rd1Adr,
  output logic [BIT_COUNT-1:0]              Rd1
`ifdef WB_SCOREBOARD_EN
  ,
  input  logic [$clog2(REGISTER_COUNT)-1:0] QueryAdr,
  output logic                              QueryPending
`endif
);

  localparam int unsigned AW = $clog2(REGISTER_COUNT);
  localparam int unsigned PW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(MAX_STARVE + 2);

  typedef enum logic [1:0] {StIdle, StBlocked, StStall} state_e;

  logic [AW-1:0]        rd_mem   [QUEUE_DEPTH];
  logic [BIT_COUNT-1:0] data_mem [QUEUE_DEPTH];

  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  state_e               state_q;
  logic [SW-1:0]        starve_q, starve_inc;
  logic                 stall_q;
  logic                 we_q;
  logic [AW-1:0]        adr_q;
  logic [BIT_COUNT-1:0] data_q;

  logic                 full, empty, push, pop, blocked, sel_valid;
  logic [AW-1:0]        sel_rd;
  logic [BIT_COUNT-1:0] sel_data;

  assign full       = (count_q == CW'(QUEUE_DEPTH));
  assign empty      = (count_q == '0);
  assign BReady     = reset && !full;
  assign push       = BValid && BReady;
  assign pop        = !AValid && !empty;
  assign blocked    = AValid && !empty;
  assign sel_valid  = AValid || !empty;
  assign sel_rd     = AValid ? ARd : rd_mem[rd_ptr_q];
  assign sel_data   = AValid ? AData : data_mem[rd_ptr_q];
  assign starve_inc = starve_q + SW'(1);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr_q]   <= BRd;
      data_mem[wr_ptr_q] <= BData;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= StIdle;
      starve_q <= '0;
      stall_q  <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      data_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;

      if (sel_valid) begin
        we_q   <= (sel_rd != '0);
        adr_q  <= sel_rd;
        data_q <= sel_data;
      end else begin
        we_q <= 1'b0;
      end

      stall_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          starve_q <= blocked ? SW'(1) : '0;
          if (blocked) begin
            if (MAX_STARVE <= 1) begin
              state_q  <= StStall;
              stall_q  <= 1'b1;
              starve_q <= '0;
            end else begin
              state_q <= StBlocked;
            end
          end
        end
        StBlocked: begin
          if (blocked) begin
            if (32'(starve_inc) >= MAX_STARVE) begin
              state_q  <= StStall;
              stall_q  <= 1'b1;
              starve_q <= '0;
            end else begin
              starve_q <= starve_inc;
            end
          end else begin
            state_q  <= StIdle;
            starve_q <= '0;
          end
        end
        StStall: begin
          // Upstream ignored the stall: this cycle already counts as one blocked cycle.
          state_q  <= blocked ? StBlocked : StIdle;
          starve_q <= blocked ? SW'(1) : '0;
        end
        default: begin
          state_q  <= StIdle;
          starve_q <= '0;
        end
      endcase
    end
  end

  assign PipeStall   = stall_q;
  assign Pending     = count_q;
  assign WriteEnable = we_q;
  assign rd1Adr      = adr_q;
  assign Rd1         = data_q;

`ifdef WB_SCOREBOARD_EN
  logic          fifo_hit;
  logic [PW-1:0] slot_off;

  always_comb begin
    fifo_hit = 1'b0;
    slot_off = '0;
    for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
      slot_off = PW'(i) - rd_ptr_q;
      if ((CW'(slot_off) < count_q) && (rd_mem[i] == QueryAdr)) fifo_hit = 1'b1;
    end
  end

  assign QueryPending = (QueryAdr != '0) && (fifo_hit || (we_q && (adr_q == QueryAdr)));
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: hand-derived vector table, starvation and query sequences,
// then random traffic against a queue-based reference model.
module tb_writeback_arbiter;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXS  = 3;

  logic        clk;
  logic        reset;
  logic        AValid, BValid, BReady, PipeStall, WriteEnable;
  logic [4:0]  ARd, BRd, rd1Adr;
  logic [31:0] AData, BData, Rd1;
  logic [2:0]  Pending;
`ifdef WB_SCOREBOARD_EN
  logic [4:0]  QueryAdr;
  logic        QueryPending;
`endif

  writeback_arbiter #(
    .BIT_COUNT     (32),
    .REGISTER_COUNT(32),
    .QUEUE_DEPTH   (DEPTH),
    .MAX_STARVE    (MAXS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .AValid      (AValid),
    .ARd         (ARd),
    .AData       (AData),
    .BValid      (BValid),
    .BReady      (BReady),
    .BRd         (BRd),
    .BData       (BData),
    .PipeStall   (PipeStall),
    .Pending     (Pending),
    .WriteEnable (WriteEnable),
    .rd1Adr      (rd1Adr),
    .Rd1         (Rd1)
`ifdef WB_SCOREBOARD_EN
    ,
    .QueryAdr    (QueryAdr),
    .QueryPending(QueryPending)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: queue of outstanding B results plus a run length of blocked cycles.
  int unsigned q_rd[$];
  logic [31:0] q_data[$];
  logic        exp_we = 1'b0;
  logic [4:0]  exp_adr = '0;
  logic [31:0] exp_data = '0;
  logic        exp_stall = 1'b0;
  int          run = 0;

  function automatic bit model_bready();
    return reset && (q_rd.size() < DEPTH);
  endfunction

  function automatic bit model_query(input logic [4:0] qa);
    if (qa == 0) return 1'b0;
    foreach (q_rd[i]) if (q_rd[i] == qa) return 1'b1;
    return exp_we && (exp_adr == qa);
  endfunction

  function automatic void model_edge();
    int unsigned sz;
    bit          blk, rdy;
    sz = q_rd.size();
    if (!reset) begin
      q_rd.delete();
      q_data.delete();
      exp_we = 0; exp_adr = 0; exp_data = 0; exp_stall = 0; run = 0;
      return;
    end
    rdy = sz < DEPTH;
    blk = AValid && (sz > 0);
    if (AValid) begin
      exp_we = (ARd != 0); exp_adr = ARd; exp_data = AData;
    end else if (sz > 0) begin
      exp_adr  = 5'(q_rd.pop_front());
      exp_data = q_data.pop_front();
      exp_we   = (exp_adr != 0);
    end else begin
      exp_we = 0;
    end
    if (BValid && rdy) begin
      q_rd.push_back(BRd);
      q_data.push_back(BData);
    end
    if (exp_stall) begin
      exp_stall = 0;
      run = blk ? 1 : 0;
    end else if (blk) begin
      run++;
      if (run >= MAXS) begin
        exp_stall = 1;
        run = 0;
      end
    end else begin
      run = 0;
    end
  endfunction

  // Inputs are already applied; checks combinational outputs, clocks once, checks registers.
  task automatic tick();
    #1;
    check("bready", BReady, model_bready());
`ifdef WB_SCOREBOARD_EN
    if (reset) check("query", QueryPending, model_query(QueryAdr));
`endif
    model_edge();
    @(posedge clk);
    #1;
    check("we", WriteEnable, exp_we);
    check("adr", rd1Adr, exp_adr);
    check("data", Rd1, exp_data);
    check("pending", Pending, q_rd.size());
    check("stall", PipeStall, exp_stall);
  endtask

  typedef struct {
    logic        rst, av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  brd;
    logic [31:0] bd;
    logic        x_bready, x_we;
    logic [4:0]  x_adr;
    logic [31:0] x_data;
    logic [2:0]  x_pend;
    logic        x_stall;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, av, input logic [4:0] ard, input logic [31:0] ad,
                              input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                              input logic xb, xwe, input logic [4:0] xadr,
                              input logic [31:0] xdata, input logic [2:0] xpend,
                              input logic xstall);
    vec_t v;
    v.rst = rst; v.av = av; v.ard = ard; v.ad = ad; v.bv = bv; v.brd = brd; v.bd = bd;
    v.x_bready = xb; v.x_we = xwe; v.x_adr = xadr; v.x_data = xdata;
    v.x_pend = xpend; v.x_stall = xstall;
    return v;
  endfunction

  task automatic run_row(input int idx, input vec_t v);
    reset = v.rst; AValid = v.av; ARd = v.ard; AData = v.ad;
    BValid = v.bv; BRd = v.brd; BData = v.bd;
    #1;
    check($sformatf("row%0d_bready", idx), BReady, v.x_bready);
    tick();
    check($sformatf("row%0d_we", idx), WriteEnable, v.x_we);
    check($sformatf("row%0d_adr", idx), rd1Adr, v.x_adr);
    check($sformatf("row%0d_data", idx), Rd1, v.x_data);
    check($sformatf("row%0d_pending", idx), Pending, v.x_pend);
    check($sformatf("row%0d_stall", idx), PipeStall, v.x_stall);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  seen;
    reset = 0; AValid = 0; ARd = 0; AData = 0; BValid = 0; BRd = 0; BData = 0;
`ifdef WB_SCOREBOARD_EN
    QueryAdr = 0;
`endif
    @(negedge clk);

    // reset, A-only, drain with A idle, fill with A held, stall, violation, drain
    vecs.push_back(mk(0,0,0,0,1,9,'h99,           0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,9,'h99,           0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,              1,0,0,0,0,0));
    vecs.push_back(mk(1,1,5,'hDEADBEEF,0,0,0,     1,1,5,'hDEADBEEF,0,0));
    vecs.push_back(mk(1,1,0,'h12345678,0,0,0,     1,0,0,'h12345678,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,              1,0,0,'h12345678,0,0));
    vecs.push_back(mk(1,0,0,0,1,1,'h11,           1,0,0,'h12345678,1,0));
    vecs.push_back(mk(1,0,0,0,1,2,'h22,           1,1,1,'h11,1,0));
    vecs.push_back(mk(1,0,0,0,1,3,'h33,           1,1,2,'h22,1,0));
    vecs.push_back(mk(1,0,0,0,1,4,'h44,           1,1,3,'h33,1,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,              1,1,4,'h44,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,              1,0,4,'h44,0,0));
    vecs.push_back(mk(1,1,6,'h66,1,1,'h101,       1,1,6,'h66,1,0));
    vecs.push_back(mk(1,1,6,'h67,1,2,'h202,       1,1,6,'h67,2,0));
    vecs.push_back(mk(1,1,6,'h68,1,3,'h303,       1,1,6,'h68,3,0));
    vecs.push_back(mk(1,1,6,'h69,1,4,'h404,       1,1,6,'h69,4,1));
    vecs.push_back(mk(1,1,6,'h6A,1,5,'h505,       0,1,6,'h6A,4,0));
    vecs.push_back(mk(1,1,6,'h6B,1,5,'h505,       0,1,6,'h6B,4,0));
    vecs.push_back(mk(1,0,0,0,1,5,'h505,          0,1,1,'h101,3,0));
    vecs.push_back(mk(1,0,0,0,1,5,'h505,          1,1,2,'h202,3,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,              1,1,3,'h303,2,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,              1,1,4,'h404,1,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,              1,1,5,'h505,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,              1,0,5,'h505,0,0));
    foreach (vecs[i]) run_row(i, vecs[i]);

    // Starvation: one queued entry, A held until the stall request appears.
    AValid = 1; ARd = 8; AData = 'h80; BValid = 1; BRd = 9; BData = 'h999;
    tick();
    check("starve_pending", Pending, 1);
    BValid = 0;
    n = 0;
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      tick();
      n++;
      if (PipeStall) seen = 1;
    end
    check("starve_seen", seen, 1);
    check("starve_cycles", n, MAXS);
    AValid = 0;
    tick();
    check("starve_we", WriteEnable, 1);
    check("starve_adr", rd1Adr, 9);
    check("starve_data", Rd1, 'h999);
    check("starve_pending0", Pending, 0);
    check("starve_stall_once", PipeStall, 0);

`ifdef WB_SCOREBOARD_EN
    AValid = 1; ARd = 3; AData = 'h3; BValid = 1; BRd = 7; BData = 'h77; QueryAdr = 7;
    tick();
    BValid = 0; #1;
    check("qp_queued", QueryPending, 1);
    QueryAdr = 0; #1;
    check("qp_zero", QueryPending, 0);
    QueryAdr = 7; AValid = 0;
    tick();
    check("qp_write_adr", rd1Adr, 7);
    check("qp_visible", QueryPending, 1);
    tick();
    check("qp_cleared", QueryPending, 0);
`endif

    // Random interleaved traffic against the reference model.
    reset = 0; AValid = 0; BValid = 0;
    tick();
    for (int c = 0; c < 300; c++) begin
      reset  = 1;
      AValid = ($urandom_range(9) < 6);
      ARd    = 5'($urandom_range(7));
      AData  = $urandom;
      BValid = ($urandom_range(9) < 7);
      BRd    = 5'($urandom_range(7));
      BData  = $urandom;
`ifdef WB_SCOREBOARD_EN
      QueryAdr = 5'($urandom_range(7));
`endif
      tick();
      check("pending_max", Pending <= DEPTH, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
